// File: rtl/matmul_pkg.sv
// Shared types and sizes for the matmul accelerator and its APB arbiter.
// TIMEOUT_CYCLES only matters when MATMUL_ARB_TIMEOUT_EN is defined.
package matmul_pkg;

    localparam int BUS_WIDTH      = 32;
    localparam int ADDR_WIDTH     = 12;
    localparam int MAX_DIM        = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0]  wdata;
        logic [MAX_DIM-1:0]    strb;
    } arb_req_t;

    // Reads never carry strobes onto the bus.
    function automatic logic [MAX_DIM-1:0] bus_strb(input logic wr, input logic [MAX_DIM-1:0] strb);
        return wr ? strb : '0;
    endfunction

endpackage

// File: rtl/matmul_apb_arb_if.sv
// Requester-side and APB-side signals of the two-requester arbiter.
// master = the arbiter, slave = requesters plus APB slave around it.
interface matmul_apb_arb_if;
    import matmul_pkg::*;

    logic [1:0]                 req_i;
    logic [1:0]                 wr_i;
    logic [1:0][ADDR_WIDTH-1:0] addr_i;
    logic [1:0][BUS_WIDTH-1:0]  wdata_i;
    logic [1:0][MAX_DIM-1:0]    strb_i;
    logic [1:0]                 lock_i;
    logic [1:0]                 gnt_o;
    logic [1:0]                 done_o;
    logic [BUS_WIDTH-1:0]       rdata_o;
    logic                       err_o;

    logic                       psel_o;
    logic                       penable_o;
    logic                       pwrite_o;
    logic [MAX_DIM-1:0]         pstrb_o;
    logic [BUS_WIDTH-1:0]       pwdata_o;
    logic [ADDR_WIDTH-1:0]      paddr_o;
    logic                       pready_i;
    logic                       pslverr_i;
    logic [BUS_WIDTH-1:0]       prdata_i;

    modport master (
        input  req_i, wr_i, addr_i, wdata_i, strb_i, lock_i,
        input  pready_i, pslverr_i, prdata_i,
        output gnt_o, done_o, rdata_o, err_o,
        output psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o, paddr_o
    );

    modport slave (
        output req_i, wr_i, addr_i, wdata_i, strb_i, lock_i,
        output pready_i, pslverr_i, prdata_i,
        input  gnt_o, done_o, rdata_o, err_o,
        input  psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o, paddr_o
    );

endinterface

// File: rtl/matmul_rr_pick.sv
// Two-way round-robin pick: the favoured requester wins when eligible,
// otherwise the other one; a locked winner keeps the priority.
module matmul_rr_pick (
    input  logic [1:0] elig_i,
    input  logic       prio_i,
    input  logic [1:0] lock_i,
    output logic       valid_o,
    output logic       pick_o,
    output logic       prio_nxt_o
);

    always_comb begin
        valid_o    = |elig_i;
        pick_o     = elig_i[prio_i] ? prio_i : ~prio_i;
        prio_nxt_o = lock_i[pick_o] ? pick_o : ~pick_o;
    end

endmodule

// File: rtl/matmul_apb_arb.sv
// Shares the matmul APB slave port between two requesters, one transfer at a time.
// Define MATMUL_ARB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES cycles.
module matmul_apb_arb
    import matmul_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    matmul_apb_arb_if.master bus
);

    arb_state_e           state_q, state_d;
    logic                 prio_q, prio_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [1:0]           done_q, done_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    arb_req_t             apb_q, apb_d;

    logic [1:0]           elig;
    logic                 pick_valid;
    logic                 pick;
    logic                 prio_nxt;
    logic                 xfer_end;

`ifdef MATMUL_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]     tmo_q, tmo_d;
`endif

    // A requester whose done pulse is out this cycle is still dropping req.
    assign elig = bus.req_i & ~done_q;

    matmul_rr_pick u_pick (
        .elig_i     (elig),
        .prio_i     (prio_q),
        .lock_i     (bus.lock_i),
        .valid_o    (pick_valid),
        .pick_o     (pick),
        .prio_nxt_o (prio_nxt)
    );

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        apb_d    = apb_q;
        xfer_end = 1'b0;
`ifdef MATMUL_ARB_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    apb_d.wr    = bus.wr_i[pick];
                    apb_d.addr  = bus.addr_i[pick];
                    apb_d.wdata = bus.wdata_i[pick];
                    apb_d.strb  = bus_strb(bus.wr_i[pick], bus.strb_i[pick]);
                    gnt_d       = pick ? 2'b10 : 2'b01;
                    prio_d      = prio_nxt;
                    state_d     = ARB_SETUP;
                end
            end

            ARB_SETUP: begin
                state_d = ARB_ACCESS;
`ifdef MATMUL_ARB_TIMEOUT_EN
                tmo_d   = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
            end

            ARB_ACCESS: begin
                if (bus.pready_i) begin
                    rdata_d  = apb_q.wr ? '0 : bus.prdata_i;
                    err_d    = bus.pslverr_i;
                    xfer_end = 1'b1;
                end
`ifdef MATMUL_ARB_TIMEOUT_EN
                // Last allowed ACCESS cycle without pready: fail the transfer.
                else if (tmo_q == '0) begin
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    xfer_end = 1'b1;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
`endif
                if (xfer_end) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = ARB_IDLE;
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            apb_q   <= '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            apb_q   <= apb_d;
`ifdef MATMUL_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.done_o    = done_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.err_o     = err_q;
    assign bus.psel_o    = (state_q != ARB_IDLE);
    assign bus.penable_o = (state_q == ARB_ACCESS);
    assign bus.pwrite_o  = apb_q.wr;
    assign bus.paddr_o   = apb_q.addr;
    assign bus.pwdata_o  = apb_q.wdata;
    assign bus.pstrb_o   = apb_q.strb;

endmodule

// File: tb/tb_matmul_apb_arb.sv
// Bench for matmul_apb_arb: directed scenarios plus randomized traffic against
// a transaction-level model of arbitration, APB phasing and completion.
module tb_matmul_apb_arb;
    import matmul_pkg::*;

    typedef struct {
        int                   waits;
        bit                   err;
        logic [BUS_WIDTH-1:0] data;
    } resp_t;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    matmul_apb_arb_if bif ();

    matmul_apb_arb dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bif)
    );

    int                   n_chk  = 0;
    int                   n_pass = 0;
    int                   n_fail = 0;
    bit                   prio_m;
    logic [1:0]           done_m;
    logic [1:0]           linger_m;
    bit                   linger_en;
    logic [BUS_WIDTH-1:0] last_rdata;
    logic                 last_err;
    resp_t                resp_q[$];
    bit                   own_log[$];
    bit                   lock_exp[8] = '{0, 0, 0, 0, 1, 0, 1, 0};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        bif.req_i = bif.req_i & ~linger_m;
        linger_m  = '0;
        done_m    = '0;
    endtask

    task automatic set_req(input bit i, input logic w, input logic [ADDR_WIDTH-1:0] a,
                           input logic [BUS_WIDTH-1:0] d, input logic [MAX_DIM-1:0] s);
        bif.req_i[i]   = 1'b1;
        bif.wr_i[i]    = w;
        bif.addr_i[i]  = a;
        bif.wdata_i[i] = d;
        bif.strb_i[i]  = s;
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        bif.req_i     = '0;
        bif.lock_i    = '0;
        bif.pready_i  = 1'b0;
        bif.pslverr_i = 1'b0;
        tick();
        tick();
        chk("reset_outputs",
            {bif.gnt_o, bif.done_o, bif.psel_o, bif.penable_o, bif.pwrite_o, bif.paddr_o,
             bif.pwdata_o, bif.pstrb_o, bif.rdata_o, bif.err_o}, '0);
        rst_i      = 1'b0;
        prio_m     = 1'b0;
        last_rdata = '0;
        last_err   = 1'b0;
        resp_q.delete();
        own_log.delete();
    endtask

    // Called one cycle after the grant: walks SETUP, ACCESS and the done cycle.
    task automatic serve(input bit own);
        resp_t                 r;
        logic [1:0]            g;
        logic                  ew;
        logic [ADDR_WIDTH-1:0] ea;
        logic [BUS_WIDTH-1:0]  ed;
        logic [MAX_DIM-1:0]    es;
        if (resp_q.size() > 0) r = resp_q.pop_front();
        else begin
            r.waits = int'($urandom_range(0, 3));
            r.err   = 1'($urandom_range(0, 1));
            r.data  = $urandom;
        end
        g  = own ? 2'b10 : 2'b01;
        ew = bif.wr_i[own];
        ea = bif.addr_i[own];
        ed = bif.wdata_i[own];
        es = ew ? bif.strb_i[own] : '0;
        own_log.push_back(own);

        chk("setup_phase", {bif.psel_o, bif.penable_o, bif.gnt_o, bif.done_o}, {1'b1, 1'b0, g, 2'b00});
        chk("setup_bus", {bif.pwrite_o, bif.paddr_o, bif.pwdata_o, bif.pstrb_o}, {ew, ea, ed, es});
        tick();
        for (int w = 0; w <= r.waits; w++) begin
            chk("access_stable",
                {bif.psel_o, bif.penable_o, bif.gnt_o, bif.done_o, bif.pwrite_o, bif.paddr_o,
                 bif.pwdata_o, bif.pstrb_o},
                {1'b1, 1'b1, g, 2'b00, ew, ea, ed, es});
            bif.pready_i  = (w == r.waits);
            bif.pslverr_i = r.err;
            bif.prdata_i  = r.data;
            tick();
        end
        bif.pready_i  = 1'b0;
        bif.pslverr_i = 1'b0;
        bif.prdata_i  = $urandom;
        last_rdata    = ew ? '0 : r.data;
        last_err      = r.err;
        chk("done_pulse", {bif.done_o, bif.gnt_o, bif.psel_o, bif.penable_o}, {g, 2'b00, 1'b0, 1'b0});
        chk("done_resp", {bif.rdata_o, bif.err_o}, {last_rdata, last_err});
        done_m = g;
        if (linger_en && ($urandom_range(0, 3) == 0)) linger_m = g;
        else bif.req_i[own] = 1'b0;
    endtask

    // Run the model until every raised request has completed.
    task automatic drain();
        int guard = 0;
        while ((bif.req_i != 2'b00) && (guard < 100)) begin
            logic [1:0] elig;
            bit         own;
            guard++;
            elig = bif.req_i & ~done_m;
            if (elig != 2'b00) begin
                own    = elig[prio_m] ? prio_m : !prio_m;
                prio_m = bif.lock_i[own] ? own : !own;
                tick();
                serve(own);
            end else begin
                tick();
                chk("idle_quiet", {bif.gnt_o, bif.psel_o, bif.done_o}, '0);
                chk("resp_hold", {bif.rdata_o, bif.err_o}, {last_rdata, last_err});
            end
        end
        chk("drain_bound", guard < 100, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bif.req_i     = '0;
        bif.wr_i      = '0;
        bif.addr_i    = '0;
        bif.wdata_i   = '0;
        bif.strb_i    = '0;
        bif.lock_i    = '0;
        bif.pready_i  = 1'b0;
        bif.pslverr_i = 1'b0;
        bif.prdata_i  = '0;
        done_m        = '0;
        linger_m      = '0;
        linger_en     = 1'b0;
        rst_i         = 1'b1;

        // Single write from requester 0, immediate pready.
        do_reset();
        set_req(1'b0, 1'b1, 12'h010, 32'h0000_00A5, 4'hF);
        resp_q.push_back('{0, 1'b0, 32'h0});
        drain();

        // Simultaneous reads, no lock: 0 then 1, back to back.
        do_reset();
        set_req(1'b0, 1'b0, 12'h040, 32'h0, 4'h0);
        set_req(1'b1, 1'b0, 12'h044, 32'h0, 4'hF);
        resp_q.push_back('{0, 1'b0, 32'h0000_1234});
        resp_q.push_back('{0, 1'b0, 32'h0000_5678});
        drain();
        chk("rr_order", {own_log.size(), own_log[0], own_log[1]}, {32'd2, 1'b0, 1'b1});

        // Lock on requester 0, then the same traffic without lock.
        do_reset();
        bif.lock_i = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            set_req(1'b0, 1'b1, ADDR_WIDTH'(k), $urandom, 4'h3);
            drain();
        end
        tick();
        set_req(1'b0, 1'b0, 12'h100, 32'h0, 4'h0);
        set_req(1'b1, 1'b0, 12'h104, 32'h0, 4'h0);
        drain();
        bif.lock_i = 2'b00;
        tick();
        set_req(1'b0, 1'b1, 12'h108, 32'h55, 4'h1);
        drain();
        tick();
        set_req(1'b0, 1'b0, 12'h10C, 32'h0, 4'h0);
        set_req(1'b1, 1'b1, 12'h110, 32'h77, 4'h8);
        drain();
        chk("lock_count", own_log.size(), 8);
        for (int k = 0; k < 8; k++) chk("lock_order", own_log[k], lock_exp[k]);

        // Four wait states with slave error.
        tick();
        set_req(1'b1, 1'b1, 12'h03C, 32'hDEAD_BEEF, 4'h5);
        resp_q.push_back('{4, 1'b1, 32'h0});
        drain();

`ifdef MATMUL_ARB_TIMEOUT_EN
        begin
            int cnt = 0;
            tick();
            set_req(1'b0, 1'b0, 12'h200, 32'h0, 4'h0);
            prio_m = bif.lock_i[0] ? 1'b0 : 1'b1;
            tick();
            tick();
            while ((bif.done_o == 2'b00) && (cnt < 40)) begin
                tick();
                cnt++;
            end
            chk("timeout_cycles", cnt, 16);
            chk("timeout_resp", {bif.done_o, bif.err_o, bif.rdata_o, bif.psel_o, bif.gnt_o},
                {2'b01, 1'b1, 32'h0, 1'b0, 2'b00});
            bif.req_i[0] = 1'b0;
            last_rdata   = '0;
            last_err     = 1'b1;
        end
`endif

        // Randomized traffic.
        linger_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int mask = int'($urandom_range(1, 3));
            bif.lock_i = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                if (mask[i])
                    set_req(1'(i), 1'($urandom_range(0, 1)), ADDR_WIDTH'($urandom),
                            $urandom, MAX_DIM'($urandom));
            end
            drain();
        end
        linger_en = 1'b0;

        // Reset in the middle of an ACCESS phase.
        tick();
        bif.lock_i = 2'b00;
        set_req(1'b0, 1'b0, 12'h300, 32'h0, 4'h0);
        tick();
        chk("abort_setup", {bif.psel_o, bif.penable_o, bif.gnt_o}, {1'b1, 1'b0, 2'b01});
        tick();
        chk("abort_access", {bif.psel_o, bif.penable_o, bif.gnt_o}, {1'b1, 1'b1, 2'b01});
        rst_i     = 1'b1;
        bif.req_i = '0;
        tick();
        chk("abort_outputs",
            {bif.gnt_o, bif.done_o, bif.psel_o, bif.penable_o, bif.pwrite_o, bif.paddr_o,
             bif.pwdata_o, bif.pstrb_o, bif.rdata_o, bif.err_o}, '0);
        rst_i      = 1'b0;
        prio_m     = 1'b0;
        last_rdata = '0;
        last_err   = 1'b0;
        own_log.delete();
        tick();
        chk("abort_no_done", {bif.done_o, bif.psel_o}, '0);
        set_req(1'b0, 1'b0, 12'h304, 32'h0, 4'h0);
        set_req(1'b1, 1'b0, 12'h308, 32'h0, 4'h0);
        resp_q.push_back('{1, 1'b0, 32'hCAFE_0001});
        resp_q.push_back('{0, 1'b0, 32'hCAFE_0002});
        drain();
        chk("post_reset_order", {own_log.size(), own_log[0], own_log[1]}, {32'd2, 1'b0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/matmul_apb_arb.md
# matmul_apb_arb

Two-requester APB master arbiter that shares the single APB slave port of the matmul accelerator (psel/penable/pwrite/pstrb/pwdata/paddr → pready/pslverr/prdata) between two on-chip requesters, e.g. the host bridge and a DMA/job engine. It accepts one simple request per requester, arbitrates round-robin with an optional lock, and runs exactly one APB transfer at a time. Completion is reported per requester as a one-cycle `done` pulse, with read data and error.

## Interface
Parameters (from `matmul_pkg`):
- `BUS_WIDTH`, package value — APB data width.
- `ADDR_WIDTH`, package value — APB address width.
- `MAX_DIM`, package value — strobe width (`pstrb` is `MAX_DIM` bits, as on the matmul slave).
- `TIMEOUT_CYCLES`, 16 — ACCESS-phase cycle limit; used only with `MATMUL_ARB_TIMEOUT_EN`.

Ports:
- `clk_i` in 1 — the single clock.
- `rst_i` in 1 — reset, synchronous, active-high.
- `req_i` in [1:0] — level request per requester; held until that requester's `done_o`.
- `wr_i` in [1:0] — 1 = write, 0 = read.
- `addr_i` in [1:0][ADDR_WIDTH] — request address.
- `wdata_i` in [1:0][BUS_WIDTH] — write data.
- `strb_i` in [1:0][MAX_DIM] — write strobes.
- `lock_i` in [1:0] — keep priority on this requester after its grant.
- `gnt_o` out [1:0] — one-hot owner of the current transfer; 0 when idle.
- `done_o` out [1:0] — one-cycle completion pulse.
- `rdata_o` out BUS_WIDTH — read data; valid with `done_o`.
- `err_o` out 1 — `pslverr`/timeout; valid with `done_o`.
- `psel_o`, `penable_o`, `pwrite_o` out 1 — APB master controls.
- `pstrb_o` out MAX_DIM — APB strobes.
- `pwdata_o` out BUS_WIDTH — APB write data.
- `paddr_o` out ADDR_WIDTH — APB address.
- `pready_i`, `pslverr_i` in 1 — APB slave response.
- `prdata_i` in BUS_WIDTH — APB read data.

## Operation
- States: IDLE, SETUP, ACCESS.
- **IDLE:**
  - A requester is eligible if its `req_i` is high and its `done_o` is low this cycle. This blocks re-grant of a request the requester is still dropping.
  - If any requester is eligible, the one favoured by the priority pointer `prio` wins; otherwise the other one wins.
  - On a grant:
    - capture `wr`/`addr`/`wdata`/`strb` into the APB output registers;
    - set `gnt_o` one-hot;
    - go to SETUP.
  - Non-write transfers drive `pstrb_o` = 0.
- **Priority update at grant:** `prio` moves to the other requester, unless `lock_i` of the winner is high, in which case `prio` stays.
- **SETUP:** `psel_o` = 1, `penable_o` = 0; lasts exactly one cycle, then go to ACCESS.
- **ACCESS:** `psel_o` = 1, `penable_o` = 1. All APB outputs stay stable until `pready_i` is sampled high.
- **On `pready_i` high in ACCESS:**
  - register `prdata_i` (reads only; writes give 0) into `rdata_o` and `pslverr_i` into `err_o`;
  - next cycle: pulse `done_o[owner]`, drop `psel_o`/`penable_o`, clear `gnt_o`, return to IDLE.
- `rdata_o` and `err_o` hold their values until the next completion.
- **Reset mid-transfer:** at the reset edge all outputs are cleared and the state returns to IDLE; no `done_o` is issued for the aborted transfer.

## Timing
- **Reset values:**
  - `gnt_o`, `done_o`, `rdata_o`, `err_o` = 0;
  - all APB outputs = 0;
  - `prdata` register = 0;
  - `prio` = requester 0;
  - state = IDLE.
- **Latency:** request seen in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2. With `pready_i` at cycle 2, `done_o` is high at cycle 3. Minimum request-to-done is 3 cycles.
- **Back-to-back:** the IDLE cycle coincides with the `done_o` cycle, so the other requester can be in SETUP the cycle after `done_o`.
- **Wait states:** each cycle `pready_i` is low adds one ACCESS cycle.
- **Simultaneous requests:** `prio` decides; without lock the grants alternate 0,1,0,1.

## Configuration
- **`MATMUL_ARB_TIMEOUT_EN` defined:**
  - a counter runs in ACCESS, cleared on entry;
  - if `TIMEOUT_CYCLES` ACCESS cycles pass without `pready_i`, the transfer ends like a normal completion: `done_o` pulse, `err_o` = 1, `rdata_o` = 0, APB dropped, return to IDLE;
  - a `pready_i` arriving in the same cycle as the limit wins (normal completion).
- **Macro undefined:** no counter; ACCESS waits indefinitely.

## Structure
- Add to `matmul_pkg`:
  - an arbiter state enum (IDLE/SETUP/ACCESS);
  - a request record typedef (`wr`, `addr`, `wdata`, `strb`);
  - default `TIMEOUT_CYCLES`.
- `BUS_WIDTH`, `ADDR_WIDTH` and `MAX_DIM` are reused from the package.
- One sub-module, `matmul_rr_pick`: combinational two-way round-robin pick from eligible mask + `prio`, with lock-aware next-`prio`. The FSM, capture registers and timeout live in `matmul_apb_arb`.

## Test plan
- Reset, then requester 0 writes addr 0x10, data 0xA5, `strb` all-ones, slave `pready` immediately:
  - cycle 1: `psel` = 1, `penable` = 0;
  - cycle 2: `penable` = 1;
  - cycle 3: `done_o` = 01, `err_o` = 0.
- Both requesters request reads together, no lock: grants are 0 then 1; 1 reaches SETUP the cycle after 0's `done`; `rdata_o` = 0x1234 then 0x5678 as returned by the slave.
- `lock_i[0]` = 1, both requesting for 3 transfers: requester 0 is granted every time while 1 waits; after `lock` drops, 1 is granted next.
- Slave inserts 4 wait states with `pslverr` = 1: APB outputs stable for 5 ACCESS cycles; `done` with `err_o` = 1.
- `MATMUL_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16, `pready` never high: `done` 16 cycles after ACCESS entry, `err_o` = 1, `rdata_o` = 0, `psel` = 0 after.
- `rst_i` pulsed in ACCESS: next cycle all outputs 0, no `done`; a new request then completes normally with `prio` = 0.
